fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Parametrised successor to the pipeline's combinational forwarding unit. Tracks in-flight destination tags for the EX, MEM and WB stages in its own shadow registers. From those tags it generates forwarding selects for NUM_SRC operands, load-use stalls, and multi-cycle (mul/div) stalls, and it handles pipeline flushes. It sits beside the ID/EX boundary of the 5-stage RISC-V core and drives the operand muxes and the IF/ID/EX enables.

Parameters:
REG_ADDR_W, 5, register index width; index 0 is hard-wired zero.
NUM_SRC, 2, number of source operands per instruction (1..3).
MDIV_LAT, 4, cycles a mul/div instruction occupies EX (>=1; 1 means no stall).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  NUM_SRC*REG_ADDR_W  source indices; operand k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
id_rs_used  in  NUM_SRC  bit k set means operand k is actually read.
id_rd  in  REG_ADDR_W  destination index.
id_reg_write  in  1  instruction writes rd.
id_is_load  in  1  instruction is a load.
id_is_mdiv  in  1  instruction is mul/div.
flush  in  1  branch/jump redirect; kill ID and EX contents.
fwd_sel  out  2*NUM_SRC  per-operand select for the EX instruction: 00 regfile, 10 EX/MEM, 01 MEM/WB.
stall_if_id  out  1  hold PC and IF/ID.
bubble_id_ex  out  1  ID/EX loads a bubble this cycle.
hold_ex  out  1  ID/EX and EX hold (mul/div in progress).
mdiv_busy  out  1  multi-cycle counter non-zero.

Behaviour:
- Shadow stages ex_*, mem_*, wb_*: valid, rd, reg_write, is_load. EX also holds rs, rs_used and is_mdiv.
- Reset: all valid bits 0, counter 0. Every output is 0 during reset and in the cycle after it.
- Effective write: stage valid && reg_write && rd != 0.
- fwd_sel[k] is combinational from the EX stage.
  - 10 if ex_rs_used[k] and mem stage is an effective write with mem_rd == ex_rs[k].
  - else 01 if ex_rs_used[k] and wb stage is an effective write with wb_rd == ex_rs[k].
  - else 00.
  - EX/MEM has priority over MEM/WB.
  - rs == 0 always gives 00.
  - If ex_valid = 0, all fields are 00.
- load_use (combinational) is set when all of the following hold: id_valid, ex_valid, ex_is_load, ex_reg_write, ex_rd != 0, and some used id_rs[k] == ex_rd.
- mdiv_busy = (cnt != 0).
  - When an instruction with is_mdiv enters EX, cnt <= MDIV_LAT-1.
  - While cnt != 0, cnt decrements by 1 per cycle.
- Priority each cycle: rst > flush > mdiv_busy > load_use > normal.
- Flush:
  - ex_valid <= 0, cnt <= 0.
  - mem <= ex (the EX instruction already executed); wb <= mem.
  - bubble_id_ex = 1; stall_if_id = 0; hold_ex = 0.
- mdiv_busy (no flush):
  - hold_ex = 1, stall_if_id = 1; EX holds.
  - mem <= bubble; wb <= mem.
  - load_use is not asserted; it is evaluated once cnt reaches 0.
- load_use (no flush, not busy):
  - stall_if_id = 1, bubble_id_ex = 1.
  - ex <= bubble, mem <= ex, wb <= mem.
  - Exactly 1 stall cycle per load-use pair.
- Normal: ex <= ID fields (valid = id_valid), mem <= ex, wb <= mem.
- Load in MEM with a matching rs in EX cannot occur after a correct stall. The load's data is then forwarded from MEM/WB (01).
- Combinations: a load followed by a dependent mul/div gives a 1-cycle load-use stall, then MDIV_LAT-1 hold cycles.

Test Plan:
1. Reset held 2 cycles with random inputs -> fwd_sel=0, stall_if_id=0, bubble_id_ex=0, hold_ex=0, mdiv_busy=0.
2. Issue add x3 (rd=3), then add x5,x3,x3 -> next cycle fwd_sel={10,10}. With one unrelated instruction in between -> {01,01}. With rd=0 -> {00,00}.
3. Issue lw x7, then add x8,x7,x1 -> stall_if_id=1 and bubble_id_ex=1 for exactly 1 cycle, then fwd_sel[0]=01, fwd_sel[1]=00.
4. MDIV_LAT=4, issue mul x9 -> mdiv_busy=1 and hold_ex=1 for 3 cycles. A dependent add x10,x9,x9 following it gets fwd_sel={10,10} after release.
5. Flush asserted in the 2nd cycle of the mul hold -> cnt=0 and hold_ex=0 next cycle, EX bubbled, wb_rd of the older instruction still retires.
6. NUM_SRC=3 build: rs3 matches both MEM and WB rd=12 -> fwd_sel[2]=10. With rs_used[2]=0 -> 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage core: shadows EX/MEM/WB destination
// tags, drives operand forwarding selects and the load-use / mul-div / flush pipeline controls.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MDIV_LAT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          id_is_mdiv,
  input  logic                          flush,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall_if_id,
  output logic                          bubble_id_ex,
  output logic                          hold_ex,
  output logic                          mdiv_busy
);

  localparam int unsigned CntW = (MDIV_LAT > 1) ? $clog2(MDIV_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MDIV_LAT - 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } wr_stage_t;

  wr_stage_t                     ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_d, ex_rs_q;
  logic [NUM_SRC-1:0]            ex_rs_used_d, ex_rs_used_q;
  logic                          ex_is_mdiv_d, ex_is_mdiv_q;
  logic [CntW-1:0]               cnt_d, cnt_q;
  logic                          rst_dly_d, rst_dly_q;

  logic                   mem_eff, wb_eff, load_use, busy, mdiv_hold, out_gate;
  logic [2*NUM_SRC-1:0]   fwd_raw;
  logic                   stall_raw, bubble_raw, hold_raw;

  always_comb begin
    mem_eff  = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
    wb_eff   = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0);
    fwd_raw  = '0;
    load_use = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ex_q.valid && ex_rs_used_q[k]) begin
        if (mem_eff && (mem_q.rd == ex_rs_q[k*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_raw[2*k +: 2] = 2'b10;
        end else if (wb_eff && (wb_q.rd == ex_rs_q[k*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_raw[2*k +: 2] = 2'b01;
        end
      end
      if (id_rs_used[k] && (id_rs[k*REG_ADDR_W +: REG_ADDR_W] == ex_q.rd)) begin
        load_use = 1'b1;
      end
    end
    load_use  = load_use && id_valid && ex_q.valid && ex_q.is_load && ex_q.reg_write &&
                (ex_q.rd != '0);
    busy      = (cnt_q != '0);
    // The counter is only ever loaded by a mul/div entering EX, so this matches busy.
    mdiv_hold = busy && ex_is_mdiv_q;
  end

  always_comb begin
    ex_d         = ex_q;
    ex_rs_d      = ex_rs_q;
    ex_rs_used_d = ex_rs_used_q;
    ex_is_mdiv_d = ex_is_mdiv_q;
    mem_d        = ex_q;
    wb_d         = mem_q;
    cnt_d        = cnt_q;
    stall_raw    = 1'b0;
    bubble_raw   = 1'b0;
    hold_raw     = 1'b0;
    rst_dly_d    = rst;
    if (flush) begin
      ex_d         = '0;
      ex_rs_d      = '0;
      ex_rs_used_d = '0;
      ex_is_mdiv_d = 1'b0;
      cnt_d        = '0;
      bubble_raw   = 1'b1;
    end else if (mdiv_hold) begin
      mem_d     = '0;
      cnt_d     = cnt_q - 1'b1;
      hold_raw  = 1'b1;
      stall_raw = 1'b1;
    end else if (load_use) begin
      ex_d         = '0;
      ex_rs_d      = '0;
      ex_rs_used_d = '0;
      ex_is_mdiv_d = 1'b0;
      stall_raw    = 1'b1;
      bubble_raw   = 1'b1;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_is_load;
      ex_rs_d        = id_rs;
      ex_rs_used_d   = id_rs_used;
      ex_is_mdiv_d   = id_valid && id_is_mdiv;
      cnt_d          = (id_valid && id_is_mdiv) ? CntLoad : '0;
    end
  end

  // Outputs are forced quiet during reset and for the first cycle after it.
  always_comb begin
    out_gate     = rst || rst_dly_q;
    fwd_sel      = out_gate ? '0 : fwd_raw;
    stall_if_id  = !out_gate && stall_raw;
    bubble_id_ex = !out_gate && bubble_raw;
    hold_ex      = !out_gate && hold_raw;
    mdiv_busy    = !out_gate && busy;
  end

  always_ff @(posedge clk) begin
    rst_dly_q <= rst_dly_d;
    if (rst) begin
      ex_q         <= '0;
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
      ex_is_mdiv_q <= 1'b0;
      mem_q        <= '0;
      wb_q         <= '0;
      cnt_q        <= '0;
    end else begin
      ex_q         <= ex_d;
      ex_rs_q      <= ex_rs_d;
      ex_rs_used_q <= ex_rs_used_d;
      ex_is_mdiv_q <= ex_is_mdiv_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a 2-operand instance for the main scenarios and a
// 3-operand instance for the third-operand forwarding cases.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_reg_write, id_is_load, id_is_mdiv, flush;
  logic [3:0] fwd_sel;
  logic       stall_if_id, bubble_id_ex, hold_ex, mdiv_busy;

  logic        id3_valid;
  logic [14:0] id3_rs;
  logic [2:0]  id3_rs_used;
  logic [4:0]  id3_rd;
  logic        id3_reg_write, id3_is_load, id3_is_mdiv, flush3;
  logic [5:0]  fwd3_sel;
  logic        stall3, bubble3, hold3, busy3;

  int n_cmp;
  int n_err;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .MDIV_LAT(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_is_mdiv   (id_is_mdiv),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .hold_ex      (hold_ex),
    .mdiv_busy    (mdiv_busy)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_SRC(3), .MDIV_LAT(4)) u_dut3 (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id3_valid),
    .id_rs        (id3_rs),
    .id_rs_used   (id3_rs_used),
    .id_rd        (id3_rd),
    .id_reg_write (id3_reg_write),
    .id_is_load   (id3_is_load),
    .id_is_mdiv   (id3_is_mdiv),
    .flush        (flush3),
    .fwd_sel      (fwd3_sel),
    .stall_if_id  (stall3),
    .bubble_id_ex (bubble3),
    .hold_ex      (hold3),
    .mdiv_busy    (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl packs {stall_if_id, bubble_id_ex, hold_ex, mdiv_busy}
  logic [3:0] ctl;
  assign ctl = {stall_if_id, bubble_id_ex, hold_ex, mdiv_busy};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used, input logic we,
                       input logic ld, input logic md, input logic fl);
    id_valid     = v;
    id_rd        = rd;
    id_rs        = {rs1, rs0};
    id_rs_used   = used;
    id_reg_write = we;
    id_is_load   = ld;
    id_is_mdiv   = md;
    flush        = fl;
    #1;
  endtask

  task automatic drive3(input logic v, input logic [4:0] rd, input logic [4:0] rs0,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] used);
    id3_valid     = v;
    id3_rd        = rd;
    id3_rs        = {rs2, rs1, rs0};
    id3_rs_used   = used;
    id3_reg_write = v;
    id3_is_load   = 1'b0;
    id3_is_mdiv   = 1'b0;
    flush3        = 1'b0;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      nxt();
    end
  endtask

  task automatic randomize_inputs();
    id_valid      = 1'($urandom);
    id_rs         = 10'($urandom);
    id_rs_used    = 2'($urandom);
    id_rd         = 5'($urandom);
    id_reg_write  = 1'($urandom);
    id_is_load    = 1'($urandom);
    id_is_mdiv    = 1'($urandom);
    flush         = 1'($urandom);
    id3_valid     = 1'($urandom);
    id3_rs        = 15'($urandom);
    id3_rs_used   = 3'($urandom);
    id3_rd        = 5'($urandom);
    id3_reg_write = 1'($urandom);
    id3_is_load   = 1'($urandom);
    id3_is_mdiv   = 1'($urandom);
    flush3        = 1'($urandom);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;

    // Reset for two cycles with random inputs, then one quiet cycle with flush raised.
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      chk("rst_fwd", {4'b0, fwd_sel}, 8'h00);
      chk("rst_ctl", {4'b0, ctl}, 8'h00);
      nxt();
    end
    rst = 1'b0;
    drive(1'b0, 5'd3, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    drive3(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("post_rst_fwd", {4'b0, fwd_sel}, 8'h00);
    chk("post_rst_ctl", {4'b0, ctl}, 8'h00);
    nxt();

    // Back-to-back RAW: EX/MEM forwarding.
    drive(1'b1, 5'd3, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_fwd", {4'b0, fwd_sel}, 8'h00);
    nxt();
    drive(1'b1, 5'd5, 5'd3, 5'd3, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("raw_noload_ctl", {4'b0, ctl}, 8'h00);
    nxt();
    nop();
    chk("fwd_exmem", {4'b0, fwd_sel}, 8'b0000_1010);
    nxt();
    // One unrelated instruction between producer and consumer: MEM/WB forwarding.
    drive(1'b1, 5'd4, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bubble_ex_fwd", {4'b0, fwd_sel}, 8'h00);
    nxt();
    drive(1'b1, 5'd6, 5'd1, 5'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();
    drive(1'b1, 5'd7, 5'd4, 5'd4, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unrelated_fwd", {4'b0, fwd_sel}, 8'h00);
    nxt();
    // Writer of x0 followed by a reader of x0.
    drive(1'b1, 5'd0, 5'd1, 5'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fwd_memwb", {4'b0, fwd_sel}, 8'b0000_0101);
    nxt();
    drive(1'b1, 5'd11, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();
    nop();
    chk("fwd_x0", {4'b0, fwd_sel}, 8'h00);
    nxt();
    idle(3);

    // Load-use: exactly one stall/bubble cycle, then MEM/WB forwarding on operand 0.
    drive(1'b1, 5'd7, 5'd2, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lw_issue_ctl", {4'b0, ctl}, 8'h00);
    nxt();
    drive(1'b1, 5'd8, 5'd7, 5'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_ctl", {4'b0, ctl}, 8'b0000_1100);
    nxt();
    drive(1'b1, 5'd8, 5'd7, 5'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_once", {4'b0, ctl}, 8'h00);
    nxt();
    nop();
    chk("load_fwd", {4'b0, fwd_sel}, 8'b0000_0001);
    nxt();
    idle(3);

    // mul x9 holds EX for three cycles; the dependent add then forwards from EX/MEM.
    drive(1'b1, 5'd9, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mul_issue_ctl", {4'b0, ctl}, 8'h00);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd10, 5'd9, 5'd9, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("mul_hold%0d", i), {4'b0, ctl}, 8'b0000_1011);
      nxt();
    end
    drive(1'b1, 5'd10, 5'd9, 5'd9, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mul_release", {4'b0, ctl}, 8'h00);
    nxt();
    nop();
    chk("mul_dep_fwd", {4'b0, fwd_sel}, 8'b0000_1010);
    nxt();
    idle(3);

    // Flush in the second hold cycle of a mul that reads the older add x13.
    drive(1'b1, 5'd13, 5'd1, 5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();
    drive(1'b1, 5'd9, 5'd13, 5'd1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();
    nop();
    chk("fl_hold1_ctl", {4'b0, ctl}, 8'b0000_1011);
    chk("fl_hold1_fwd", {4'b0, fwd_sel}, 8'b0000_0010);
    nxt();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_ctl", {4'b0, ctl}, 8'b0000_0101);
    chk("flush_old_wb", {4'b0, fwd_sel}, 8'b0000_0001);
    nxt();
    drive(1'b1, 5'd14, 5'd9, 5'd2, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_ctl", {4'b0, ctl}, 8'h00);
    chk("post_flush_fwd", {4'b0, fwd_sel}, 8'h00);
    nxt();
    nop();
    chk("flushed_mul_wb", {4'b0, fwd_sel}, 8'b0000_0001);
    nxt();

    // Three-operand instance: operand 2 matches both MEM and WB; MEM wins.
    drive3(1'b1, 5'd12, 5'd1, 5'd1, 5'd1, 3'b111);
    nxt();
    drive3(1'b1, 5'd12, 5'd1, 5'd1, 5'd1, 3'b111);
    nxt();
    drive3(1'b1, 5'd15, 5'd1, 5'd2, 5'd12, 3'b111);
    nxt();
    drive3(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("src3_fwd", {2'b0, fwd3_sel}, 8'b0010_0000);
    nxt();
    drive3(1'b1, 5'd12, 5'd1, 5'd1, 5'd1, 3'b111);
    nxt();
    drive3(1'b1, 5'd12, 5'd1, 5'd1, 5'd1, 3'b111);
    nxt();
    drive3(1'b1, 5'd15, 5'd1, 5'd2, 5'd12, 3'b011);
    nxt();
    drive3(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000);
    chk("src3_unused", {2'b0, fwd3_sel}, 8'h00);
    chk("src3_ctl", {4'b0, stall3, bubble3, hold3, busy3}, 8'h00);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
